audio_adc_rx: RTL
=================

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, sample width per channel (16..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, stereo frames buffered (power of two, 2..16).
REQ-003 SHALL have port clk_clk  input  1  system clock; sole clock; frequency at least 4x audio_BCLK.
REQ-004 SHALL have port reset_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  receiver enable; low forces IDLE and blocks pushes.
REQ-006 SHALL have port audio_BCLK  input  1  codec bit clock, asynchronous to clk_clk.
REQ-007 SHALL have port audio_ADCLRCK  input  1  codec ADC word clock; low = left, high = right.
REQ-008 SHALL have port audio_ADCDAT  input  1  codec ADC serial data, I2S format, MSB first.
REQ-009 SHALL have port out_left  output  DATA_WIDTH  left sample at FIFO head.
REQ-010 SHALL have port out_right  output  DATA_WIDTH  right sample at FIFO head.
REQ-011 SHALL have port out_valid  output  1  FIFO head holds a frame.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the head frame.
REQ-013 SHALL have port fill_level  output  clog2(FIFO_DEPTH)+1  frames currently stored.
REQ-014 SHALL have port overflow  output  1  sticky flag, a frame was dropped.
REQ-015 SHALL have port overflow_clr  input  1  one-cycle pulse clearing overflow.
REQ-016 SHALL have port ovf_count  output  16  dropped-frame count (see Configuration).

Function
REQ-017 SHALL pass audio_BCLK, audio_ADCLRCK and audio_ADCDAT through 2-flop synchronizers; BCLK rising edge detected from a third history flop.
REQ-018 SHALL perform all serial actions only in the clk_clk cycle of a detected BCLK rising edge ("bit tick").
REQ-019 SHALL detect a word boundary at a bit tick whose synchronized LRCK differs from the value latched at the previous bit tick; that tick is the I2S one-bit delay slot and SHALL NOT sample data.
REQ-020 SHALL sample ADCDAT on the DATA_WIDTH bit ticks following the delay slot, MSB first; further ticks in the word SHALL be ignored.
REQ-021 SHALL zero-fill remaining LSBs when a word ends before DATA_WIDTH bits are captured.
REQ-022 SHALL implement states IDLE, LEFT, RIGHT: IDLE->LEFT on LRCK falling boundary; LEFT->RIGHT on rising boundary; RIGHT->LEFT on falling boundary.
REQ-023 SHALL push the {left,right} frame in the cycle after the RIGHT->LEFT boundary tick; the partial word in progress at IDLE exit is never pushed.
REQ-024 SHALL return to IDLE within one cycle of enable low, discarding partial words; FIFO contents are retained.
REQ-025 SHALL drive out_valid high the cycle after a push into an empty FIFO, with head data valid in that same cycle.
REQ-026 SHALL pop on out_valid and out_ready; head data and out_valid SHALL remain stable while out_valid and not out_ready.
REQ-027 SHALL accept a push when full if a pop occurs in the same cycle; fill_level then unchanged.
REQ-028 SHALL drop the incoming frame when full without pop, and set overflow the next cycle.
REQ-029 SHALL give overflow set priority over overflow_clr in the same cycle.
REQ-030 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-031 SHALL, on reset_reset_n low, asynchronously force: state IDLE, out_valid 0, out_left/out_right 0, fill_level 0, overflow 0, ovf_count 0, synchronizers 0, pointers 0.
REQ-032 SHALL, after reset release, wait for a falling LRCK boundary before capturing, even mid-word.

Configuration
REQ-033 SHALL, with macro AUDIO_ADC_RX_OVF_COUNT_EN defined, increment ovf_count on each dropped frame, saturating at 16'hFFFF, cleared by overflow_clr unless a drop occurs in the same cycle.
REQ-034 SHALL, without AUDIO_ADC_RX_OVF_COUNT_EN, drive ovf_count constant 0 and include no counter logic; overflow flag unaffected.

Verification
REQ-035 Left 24'hA5A5A5, right 24'h5A5A5A, 32 BCLK per word, out_ready=1 -> one frame with exact values, out_valid one cycle after push.
REQ-036 16-bit words from codec, DATA_WIDTH=24, left 16'h8001 -> out_left 24'h800100.
REQ-037 out_ready=0, 5 frames, FIFO_DEPTH=4 -> fill_level 4, overflow 1, ovf_count 1 (macro on) / 0 (off), first 4 frames intact.
REQ-038 Reset asserted mid right word, released mid left word -> no frame until after next full LEFT+RIGHT pair; all outputs 0 during reset.
REQ-039 FIFO full, push and pop in same cycle -> fill_level stays 4, no overflow, popped frame is oldest.
REQ-040 enable dropped mid-frame then raised -> partial frame discarded, capture resumes at next falling LRCK boundary.

Source files
------------

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronizes codec BCLK/LRCK/DAT, captures stereo frames, buffers them in a FIFO.
// Define AUDIO_ADC_RX_OVF_COUNT_EN to build the saturating dropped-frame counter behind ovf_count.
module audio_adc_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          enable,
  input  logic                          audio_BCLK,
  input  logic                          audio_ADCLRCK,
  input  logic                          audio_ADCDAT,
  output logic [DATA_WIDTH-1:0]         out_left,
  output logic [DATA_WIDTH-1:0]         out_right,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [15:0]                   ovf_count,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

  // Output handshake: a frame moves out of the FIFO in any cycle where out_valid and
  // out_ready are both high at the clock edge; head data is held while out_ready is low.

  logic [2:0]            bclk_sync;
  logic [1:0]            lrck_sync;
  logic [1:0]            dat_sync;
  logic                  lrck_prev;
  logic                  tick;
  logic                  boundary;
  logic                  lrck;
  logic                  dat;
  state_t                state;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [DATA_WIDTH-1:0] right_hold;
  logic                  push;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], audio_BCLK};
      lrck_sync <= {lrck_sync[0], audio_ADCLRCK};
      dat_sync  <= {dat_sync[0], audio_ADCDAT};
    end
  end

  assign lrck     = lrck_sync[1];
  assign dat      = dat_sync[1];
  assign tick     = bclk_sync[1] & ~bclk_sync[2];
  assign boundary = tick & (lrck != lrck_prev);

  // The boundary tick is the I2S delay slot; mask walks MSB->LSB so short words stay zero-filled.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      lrck_prev  <= 1'b0;
      word       <= '0;
      mask       <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      push       <= 1'b0;
    end else begin
      push <= 1'b0;
      if (tick) lrck_prev <= lrck;
      if (!enable) begin
        state <= IDLE;
        word  <= '0;
        mask  <= '0;
      end else if (boundary) begin
        word <= '0;
        mask <= MSB_MASK;
        case (state)
          IDLE:  if (!lrck) state <= LEFT;
          LEFT:  if (lrck) begin
                   state     <= RIGHT;
                   left_hold <= word;
                 end
          RIGHT: if (!lrck) begin
                   state      <= LEFT;
                   right_hold <= word;
                   push       <= 1'b1;
                 end
          default: state <= IDLE;
        endcase
      end else if (tick && (state != IDLE) && (mask != '0)) begin
        if (dat) word <= word | mask;
        mask <= mask >> 1;
      end
    end
  end

  assign dbg_state = state;

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    pop;
  logic                    full;
  logic                    wr;
  logic                    drop;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == FULL_LVL);
  assign wr        = push & enable & (~full | pop);
  assign drop      = push & enable & full & ~pop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= {left_hold, right_hold};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {out_left, out_right} = mem[rd_ptr];
  assign fill_level            = count;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)    overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef AUDIO_ADC_RX_OVF_COUNT_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end else if (overflow_clr) begin
      ovf_cnt <= '0;
    end
  end

  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = 16'd0;
`endif

endmodule
